// File: rtl/inv_25519.sv
// inv_25519: a^EXP mod (2^255-19) via MSB-first square/multiply ladder driving an external mul_25519.
// Optional INV25519_ZERO_FLAG_EN adds zero_err and short-circuits a==0 / a==p inputs.
`default_nettype none

module inv_25519 #(
  parameter logic [254:0] EXP = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] a,
  output logic [254:0] res,
  output logic         done,
  output logic         busy,
  output logic         mul_start,
  output logic [254:0] mul_a,
  output logic [254:0] mul_b,
  input  logic [254:0] mul_res,
  input  logic         mul_done
`ifdef INV25519_ZERO_FLAG_EN
  ,
  output logic         zero_err
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    SQR_REQ  = 3'd2,
    SQR_WAIT = 3'd3,
    MUL_REQ  = 3'd4,
    MUL_WAIT = 3'd5,
    FIN      = 3'd6
  } state_e;

  state_e       state_q, state_d;
  logic [254:0] acc_q, acc_d;
  logic [254:0] base_q, base_d;
  logic [7:0]   idx_q, idx_d;
  logic [254:0] res_q, res_d;
  logic [254:0] mul_a_q, mul_a_d;
  logic [254:0] mul_b_q, mul_b_d;

`ifdef INV25519_ZERO_FLAG_EN
  localparam logic [254:0] P = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFED;
  logic zflag_q, zflag_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
`ifdef INV25519_ZERO_FLAG_EN
      zflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
`ifdef INV25519_ZERO_FLAG_EN
      zflag_q <= zflag_d;
`endif
    end
  end

  // Operands are loaded on the transition into a REQ state, so they are
  // already stable when mul_start rises and stay put through the WAIT state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    idx_d   = idx_q;
    res_d   = res_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
`ifdef INV25519_ZERO_FLAG_EN
    zflag_d = zflag_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = a;
          acc_d   = 255'd1;
          idx_d   = 8'd254;
          state_d = SCAN;
`ifdef INV25519_ZERO_FLAG_EN
          zflag_d = 1'b0;
          if ((a == '0) || (a == P)) begin
            acc_d   = '0;
            res_d   = '0;
            zflag_d = 1'b1;
            state_d = FIN;
          end
`endif
        end
      end
      SCAN: begin
        if (EXP[idx_q]) begin
          acc_d = base_q;
          if (idx_q == 8'd0) begin
            res_d   = base_q;
            state_d = FIN;
          end else begin
            idx_d   = idx_q - 8'd1;
            mul_a_d = base_q;
            mul_b_d = base_q;
            state_d = SQR_REQ;
          end
        end else if (idx_q == 8'd0) begin
          res_d   = acc_q;
          state_d = FIN;
        end else begin
          idx_d = idx_q - 8'd1;
        end
      end
      SQR_REQ: state_d = SQR_WAIT;
      MUL_REQ: state_d = MUL_WAIT;
      SQR_WAIT, MUL_WAIT: begin
        if (mul_done) begin
          acc_d = mul_res;
          if ((state_q == SQR_WAIT) && EXP[idx_q]) begin
            mul_a_d = mul_res;
            mul_b_d = base_q;
            state_d = MUL_REQ;
          end else if (idx_q == 8'd0) begin
            res_d   = mul_res;
            state_d = FIN;
          end else begin
            idx_d   = idx_q - 8'd1;
            mul_a_d = mul_res;
            mul_b_d = mul_res;
            state_d = SQR_REQ;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign res       = res_q;
  assign done      = (state_q == FIN);
  assign busy      = (state_q != IDLE);
  assign mul_start = (state_q == SQR_REQ) || (state_q == MUL_REQ);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
`ifdef INV25519_ZERO_FLAG_EN
  assign zero_err  = zflag_q && (state_q == FIN);
`endif

endmodule

`default_nettype wire

// File: tb/tb_inv_25519.sv
// Scoreboard bench for inv_25519 with a behavioural modular multiplier model.
`default_nettype none

module tb_inv_25519;

  localparam logic [254:0] P    = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFED;
  localparam logic [254:0] PM1  = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEC;
  localparam logic [254:0] PP1  = 255'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEE;
  localparam logic [254:0] HALF = 255'h3FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF7;
  localparam logic [254:0] QUAR = 255'h5FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2;
  localparam int MUL_LAT = 2;
  localparam int TMO     = 4000;

  typedef struct {
    logic [254:0] a;
    logic [254:0] res;
    int           ops;
    bit           inv;
    bit           zerr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [254:0] a = '0;
  logic [254:0] res;
  logic         done, busy, mul_start;
  logic [254:0] mul_a, mul_b;
  logic [254:0] mul_res = '0;
  logic         mdl_done = 1'b0;
  logic         stray_done = 1'b0;
  logic         mul_done;
  logic         mdl_pend = 1'b0;
  int           mdl_cnt = 0;
  logic [254:0] lat_a = '0, lat_b = '0;
  bit           end_req = 1'b0;
  exp_t         sb[$];

`ifdef INV25519_ZERO_FLAG_EN
  logic zero_err;
`endif

  assign mul_done = mdl_done | stray_done;

  inv_25519 dut (
    .clk(clk), .rst(rst_n), .start(start), .a(a), .res(res), .done(done), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res), .mul_done(mul_done)
`ifdef INV25519_ZERO_FLAG_EN
    , .zero_err(zero_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [254:0] mulmod(input logic [254:0] x, input logic [254:0] y);
    logic [509:0] t;
    logic [509:0] pw;
    t  = {255'd0, x} * {255'd0, y};
    pw = {255'd0, P};
    t  = t % pw;
    return t[254:0];
  endfunction

  // Behavioural multiplier: fixed latency, single outstanding request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_pend <= 1'b0;
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
    end else begin
      mdl_done <= 1'b0;
      if (mul_start) begin
        mdl_pend <= 1'b1;
        mdl_cnt  <= MUL_LAT;
        lat_a    <= mul_a;
        lat_b    <= mul_b;
      end else if (mdl_pend) begin
        if (mdl_cnt == 0) begin
          mdl_done <= 1'b1;
          mul_res  <= mulmod(lat_a, lat_b);
          mdl_pend <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
    end
  end

  // Monitor / checker
  int n_cmp = 0;
  int n_bad = 0;
  bit run = 1'b0;
  int cyc = 0;
  int ops = 0;
  bit busy_ok = 1'b1;
  bit proto_ok = 1'b1;
  bit stable_ok = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_cmp++;
      if (done || busy || mul_start || (mul_a != '0) || (mul_b != '0) || (res != '0)) begin
        n_bad++;
        $display("FAIL reset_outputs: done=%0b busy=%0b mul_start=%0b res=%h required all zero",
                 done, busy, mul_start, res);
      end
      run = 1'b0;
    end else begin
      if (run) begin
        cyc++;
        if (!busy) busy_ok = 1'b0;
        if (mul_start && mdl_pend) proto_ok = 1'b0;
        if (mdl_pend && ((mul_a != lat_a) || (mul_b != lat_b))) stable_ok = 1'b0;
        if (mul_start) ops++;
        if (done) begin
          run = 1'b0;
          if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: res=%h with no expected entry", res);
          end else begin
            e = sb.pop_front();
            n_cmp++;
            if (res != e.res) begin
              n_bad++;
              $display("FAIL res: a=%h got %h required %h", e.a, res, e.res);
            end
            n_cmp++;
            if (ops != e.ops) begin
              n_bad++;
              $display("FAIL op_count: a=%h got %0d required %0d", e.a, ops, e.ops);
            end
            n_cmp++;
            if (!busy_ok || !proto_ok || !stable_ok) begin
              n_bad++;
              $display("FAIL handshake: busy_ok=%0b proto_ok=%0b stable_ok=%0b required 1 1 1",
                       busy_ok, proto_ok, stable_ok);
            end
            if (e.inv) begin
              n_cmp++;
              if (mulmod(e.a, res) != 255'd1) begin
                n_bad++;
                $display("FAIL inverse: a*res mod p = %h required 1", mulmod(e.a, res));
              end
            end
`ifdef INV25519_ZERO_FLAG_EN
            n_cmp++;
            if (zero_err != e.zerr) begin
              n_bad++;
              $display("FAIL zero_err: got %0b required %0b", zero_err, e.zerr);
            end
`endif
          end
        end else if (cyc > TMO) begin
          n_cmp++; n_bad++;
          $display("FAIL timeout: no done after %0d cycles, required completion", cyc);
          run = 1'b0;
        end
      end else if (done) begin
        n_cmp++; n_bad++;
        $display("FAIL stray_done: done=1 outside a run, required 0");
      end
      if (start && !busy) begin
        run = 1'b1; cyc = 0; ops = 0;
        busy_ok = 1'b1; proto_ok = 1'b1; stable_ok = 1'b1;
      end
    end
    if (end_req) begin
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL leftover: %0d expected results never produced, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  // Stimulus
  task automatic issue(input logic [254:0] v, input bit push, input logic [254:0] r,
                       input bit inv, input bit is_zero);
    exp_t e;
    e.a = v; e.res = r; e.inv = inv; e.ops = 506; e.zerr = 1'b0;
`ifdef INV25519_ZERO_FLAG_EN
    if (is_zero) begin e.ops = 0; e.zerr = 1'b1; end
`endif
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; a = v;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < TMO + 50; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
  endtask

  task automatic run_one(input logic [254:0] v, input logic [254:0] r, input bit inv, input bit is_zero);
    issue(v, 1'b1, r, inv, is_zero);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_one(255'd1, 255'd1, 1'b1, 1'b0);
    run_one(255'd2, HALF,   1'b1, 1'b0);
    run_one(PM1,    PM1,    1'b1, 1'b0);
    run_one(PP1,    255'd1, 1'b1, 1'b0);
    run_one(HALF,   255'd2, 1'b1, 1'b0);
    run_one(255'd4, QUAR,   1'b1, 1'b0);
    run_one(255'd0, 255'd0, 1'b0, 1'b1);
    run_one(P,      255'd0, 1'b0, 1'b1);

    // Second start with a different base while busy must be ignored.
    issue(255'd2, 1'b1, HALF, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; a = 255'd5;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();

    // mul_done while idle must have no effect.
    @(posedge clk); #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;
    run_one(255'd1, 255'd1, 1'b1, 1'b0);

    // Abort mid-run, then a clean rerun.
    issue(255'd2, 1'b0, '0, 1'b0, 1'b0);
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_one(PM1, PM1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    end_req = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL end: summary not reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
